// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush control for the 5-stage MIPS pipeline.
// Drives PC and IF/ID, ID/EX, EX/MEM, MEM/WB latch enables and bubble-inserts,
// resolves load-use, cache-miss and redirect hazards, and runs the halt drain.
// Optional build macro: PIPE_STATS_EN (load-use / mem-wait / flush counters).
module pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic [31:0]      instr_id,
    input  logic             idex_memread,
    input  logic [4:0]       idex_wsel,
    input  logic             pc_redirect,
    input  logic             halt_ex,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mw_cnt,
    output logic [CNT_W-1:0] fl_cnt
);

    localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(DRAIN_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;

    logic mem_wait_s;
    logic load_use_s;
    logic lu_hit_s;
    logic mw_hit_s;
    logic fl_hit_s;

    // Only the source-register fields of the ID instruction matter here.
    logic instr_unused_s;
    assign instr_unused_s = ^{instr_id[31:26], instr_id[15:0]};

    // Hazard detection and priority resolution into enables, flushes and next state.
    always_comb begin
        mem_wait_s = dmem_req & ~dhit;
        load_use_s = idex_memread & (idex_wsel != 5'd0) &
                     ((idex_wsel == instr_id[25:21]) | (idex_wsel == instr_id[20:16]));

        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        lu_hit_s   = 1'b0;
        mw_hit_s   = 1'b0;
        fl_hit_s   = 1'b0;

        if (RST) begin
            // Everything held low while reset is asserted.
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_wait_s) begin
                        // Whole pipeline holds; outputs stay at their all-zero defaults.
                        mw_hit_s = 1'b1;
                    end else if (halt_ex) begin
                        // Squash the wrong-path slots behind HALT and start draining.
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        state_d    = ST_DRAIN;
                        dcnt_d     = DRAIN_INIT;
                    end else if (pc_redirect) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        fl_hit_s   = 1'b1;
                    end else if (load_use_s) begin
                        // Hold PC and IF/ID, drop one bubble into ID/EX.
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        idex_flush = 1'b1;
                        lu_hit_s   = 1'b1;
                    end else if (!ihit) begin
                        // Fetch not ready: hold PC, feed a bubble into IF/ID.
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (mem_wait_s) begin
                        // Frozen; drain count holds until memory completes.
                        dcnt_d = dcnt_q;
                    end else begin
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        dcnt_d     = dcnt_q - DCNT_ONE;
                        if (dcnt_q <= DCNT_ONE) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    // Sequencer state and drain counter, synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mw_cnt_q, mw_cnt_d;
    logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

    // Saturating event counters; hit flags only ever fire in RUN.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        mw_cnt_d = mw_cnt_q;
        fl_cnt_d = fl_cnt_q;
        if (lu_hit_s && (lu_cnt_q != {CNT_W{1'b1}})) begin
            lu_cnt_d = lu_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            lu_cnt_d = lu_cnt_q;
        end
        if (mw_hit_s && (mw_cnt_q != {CNT_W{1'b1}})) begin
            mw_cnt_d = mw_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            mw_cnt_d = mw_cnt_q;
        end
        if (fl_hit_s && (fl_cnt_q != {CNT_W{1'b1}})) begin
            fl_cnt_d = fl_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            fl_cnt_d = fl_cnt_q;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lu_cnt_q <= '0;
            mw_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            mw_cnt_q <= mw_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    assign lu_cnt = lu_cnt_q;
    assign mw_cnt = mw_cnt_q;
    assign fl_cnt = fl_cnt_q;
`else
    // Statistics disabled: ports tied low, hit flags intentionally unused.
    logic stats_unused_s;
    assign stats_unused_s = lu_hit_s ^ mw_hit_s ^ fl_hit_s;
    assign lu_cnt = {CNT_W{1'b0}};
    assign mw_cnt = {CNT_W{1'b0}};
    assign fl_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed hazard scenarios plus
// randomized traffic, compared against a priority-rule reference model.
module tb_pipeline_sequencer;

    localparam int DRAIN = 2;
`ifdef PIPE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Hazard classes, in the order the sequencer resolves them.
    localparam int C_RST = 0, C_MW = 1, C_HALT = 2, C_RED = 3, C_LU = 4,
                   C_IMISS = 5, C_NORM = 6, C_DRAIN = 7, C_HALTED = 8;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, dmem_req, idex_memread, pc_redirect, halt_ex;
    logic [31:0] instr_id;
    logic [4:0]  idex_wsel;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, halted;
    logic [31:0] lu_cnt, mw_cnt, fl_cnt;

    int          n_vec  = 0;
    int          n_miss = 0;

    // Reference model state: mode 0=running, 1=draining, 2=halted.
    int          m_mode = 0;
    int          m_left = 0;
    logic [31:0] m_lu = 32'd0, m_mw = 32'd0, m_fl = 32'd0;
    logic [7:0]  got_ctrl;

    pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .instr_id(instr_id), .idex_memread(idex_memread), .idex_wsel(idex_wsel),
        .pc_redirect(pc_redirect), .halt_ex(halt_ex),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .lu_cnt(lu_cnt), .mw_cnt(mw_cnt), .fl_cnt(fl_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_load_use();
        return idex_memread && (idex_wsel != 5'd0) &&
               ((idex_wsel == instr_id[25:21]) || (idex_wsel == instr_id[20:16]));
    endfunction

    function automatic int classify();
        bit mw;
        mw = dmem_req && !dhit;
        if (RST) return C_RST;
        if (m_mode == 2) return C_HALTED;
        if (m_mode == 1) return mw ? C_MW : C_DRAIN;
        if (mw) return C_MW;
        if (halt_ex) return C_HALT;
        if (pc_redirect) return C_RED;
        if (model_load_use()) return C_LU;
        if (!ihit) return C_IMISS;
        return C_NORM;
    endfunction

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, halted}
    function automatic logic [7:0] ctrl_of(input int c);
        case (c)
            C_HALT, C_DRAIN: return 8'b0111_1110;
            C_RED:           return 8'b1111_1110;
            C_LU:            return 8'b0011_1010;
            C_IMISS:         return 8'b0111_1100;
            C_NORM:          return 8'b1111_1000;
            C_HALTED:        return 8'b0000_0001;
            default:         return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] stat(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    // One clock: compare controls before the edge, advance model, compare counters after.
    task automatic cycle();
        int c;
        @(negedge CLK);
        c = classify();
        got_ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};
        check_val("ctrl", {24'd0, got_ctrl}, {24'd0, ctrl_of(c)});
        @(posedge CLK);
        case (c)
            C_RST:   begin m_mode = 0; m_left = 0; m_lu = 32'd0; m_mw = 32'd0; m_fl = 32'd0; end
            C_MW:    if (m_mode == 0) m_mw = sat_inc(m_mw);
            C_HALT:  begin m_mode = 1; m_left = DRAIN; end
            C_RED:   m_fl = sat_inc(m_fl);
            C_LU:    m_lu = sat_inc(m_lu);
            C_DRAIN: begin m_left--; if (m_left == 0) m_mode = 2; end
            default: ;
        endcase
        #1;
        check_val("lu_cnt", lu_cnt, stat(m_lu));
        check_val("mw_cnt", mw_cnt, stat(m_mw));
        check_val("fl_cnt", fl_cnt, stat(m_fl));
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b1; dmem_req = 1'b0; idex_memread = 1'b0;
        idex_wsel = 5'd0; pc_redirect = 1'b0; halt_ex = 1'b0; instr_id = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        // Reset state.
        cycle();
        check_val("rst_ctrl", {24'd0, got_ctrl}, 32'h0000_0000);
        RST = 1'b0;

        // Load-use: lw $2 in ID/EX, add with rs=2 in ID.
        idex_memread = 1'b1; idex_wsel = 5'd2; instr_id = {6'd0, 5'd2, 5'd3, 5'd4, 11'h020};
        cycle();
        check_val("lu_bubble", {24'd0, got_ctrl}, 32'h0000_003A);
        idex_memread = 1'b0; idex_wsel = 5'd3;
        cycle();
        check_val("lu_after", {24'd0, got_ctrl}, 32'h0000_00F8);
        check_val("lu_cnt_one", lu_cnt, stat(32'd1));

        // Load into $0 never stalls.
        idex_memread = 1'b1; idex_wsel = 5'd0; instr_id = 32'd0;
        cycle();
        check_val("lu_zero_reg", {24'd0, got_ctrl}, 32'h0000_00F8);

        // Three mem-wait cycles over a pending load-use, then the bubble.
        do_reset();
        idex_memread = 1'b1; idex_wsel = 5'd7; instr_id = {6'd0, 5'd1, 5'd7, 16'd0};
        dmem_req = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("mw_freeze", {24'd0, got_ctrl}, 32'h0000_0000);
        end
        dhit = 1'b1;
        cycle();
        check_val("mw_then_lu", {24'd0, got_ctrl}, 32'h0000_003A);
        check_val("mw_cnt_three", mw_cnt, stat(32'd3));

        // Redirect beats load-use and fetch miss.
        do_reset();
        idex_memread = 1'b1; idex_wsel = 5'd5; instr_id = {6'd0, 5'd5, 5'd0, 16'd0};
        ihit = 1'b0; pc_redirect = 1'b1;
        cycle();
        check_val("redirect", {24'd0, got_ctrl}, 32'h0000_00FE);
        check_val("fl_cnt_one", fl_cnt, stat(32'd1));
        check_val("lu_unchanged", lu_cnt, 32'd0);
        idle_inputs();
        ihit = 1'b0;
        cycle();
        check_val("imiss", {24'd0, got_ctrl}, 32'h0000_007C);

        // Halt with one frozen drain cycle: halted exactly 4 cycles after entry.
        do_reset();
        halt_ex = 1'b1; pc_redirect = 1'b1;
        cycle();
        check_val("halt_entry", {24'd0, got_ctrl}, 32'h0000_007E);
        idle_inputs();
        dmem_req = 1'b1; dhit = 1'b0;
        cycle();
        check_val("drain_frozen", {24'd0, got_ctrl}, 32'h0000_0000);
        dhit = 1'b1;
        cycle();
        cycle();
        check_val("drain_last", {24'd0, got_ctrl}, 32'h0000_007E);
        idle_inputs();
        cycle();
        check_val("halted_now", {24'd0, got_ctrl}, 32'h0000_0001);
        pc_redirect = 1'b1; halt_ex = 1'b1;
        cycle();
        check_val("halted_sticky", {24'd0, got_ctrl}, 32'h0000_0001);

        // Reset pulsed mid-drain returns to normal running.
        do_reset();
        halt_ex = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        RST = 1'b1;
        cycle();
        check_val("rst_mid_drain", {24'd0, got_ctrl}, 32'h0000_0000);
        RST = 1'b0;
        cycle();
        check_val("run_after_rst", {24'd0, got_ctrl}, 32'h0000_00F8);
        check_val("cnt_after_rst", lu_cnt | mw_cnt | fl_cnt, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] rs, rt;
            RST          = ($urandom_range(0, 99) < 2);
            ihit         = ($urandom_range(0, 99) < 80);
            dmem_req     = ($urandom_range(0, 99) < 40);
            dhit         = ($urandom_range(0, 99) < 60);
            idex_memread = ($urandom_range(0, 99) < 40);
            idex_wsel    = 5'($urandom_range(0, 3));
            rs           = 5'($urandom_range(0, 3));
            rt           = 5'($urandom_range(0, 3));
            instr_id     = {6'($urandom), rs, rt, 16'($urandom)};
            pc_redirect  = ($urandom_range(0, 99) < 15);
            halt_ex      = ($urandom_range(0, 99) < 3);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
